// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan driver for an N-digit common-anode 7-seg display.
// Frames load through valid/ready and commit only at a frame boundary, so the display never tears.
module seg_scan_driver #(
    parameter int unsigned NDIGITS     = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6*NDIGITS-1:0]   in_codes,
    input  logic                   blank_lz,
    input  logic                   en,
    output logic [NDIGITS-1:0]     an,
    output logic [5:0]             code,
    output logic                   frame_start
);

    localparam int unsigned CODE_W = 6;
    localparam int unsigned IDX_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int unsigned DIV_W  = $clog2(REFRESH_DIV);
    localparam logic [CODE_W-1:0] BLANK = 6'h3F;

    logic [DIV_W-1:0]                div;
    logic [IDX_W-1:0]                idx;
    logic [NDIGITS-1:0][CODE_W-1:0]  disp;
    logic [NDIGITS-1:0][CODE_W-1:0]  pend;
    logic                            pend_full;
    logic                            en_r;
    logic                            blank_r;

    logic                            tick;
    logic                            last;
    logic                            commit;
    logic                            xfer;
    logic [NDIGITS-1:0]              zero_tail;
    logic                            lit;

    assign tick     = (div == DIV_W'(REFRESH_DIV - 1));
    assign last     = (idx == IDX_W'(NDIGITS - 1));
    assign commit   = tick & last & pend_full;
    assign xfer     = in_valid & ~pend_full;
    assign in_ready = ~pend_full;

    // Refresh divider, digit index and frame-boundary pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div         <= '0;
            idx         <= '0;
            frame_start <= 1'b0;
        end else begin
            div         <= tick ? '0 : div + DIV_W'(1);
            frame_start <= tick & last;
            if (tick) begin
                idx <= last ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Pending/display frame buffers; commit and transfer are mutually exclusive on pend_full
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp      <= {NDIGITS{BLANK}};
            pend      <= '0;
            pend_full <= 1'b0;
        end else if (commit) begin
            disp      <= pend;
            pend_full <= 1'b0;
        end else if (xfer) begin
            pend      <= in_codes;
            pend_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_r    <= 1'b0;
            blank_r <= 1'b0;
        end else begin
            en_r    <= en;
            blank_r <= blank_lz;
        end
    end

    // zero_tail[i] = every digit from i up to the leftmost holds code 00
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        zero_tail = '0;
        for (int i = int'(NDIGITS) - 1; i >= 0; i--) begin
            all_zero     = all_zero & (disp[i] == '0);
            zero_tail[i] = all_zero;
        end
    end

    always_comb begin
        lit  = en_r & ~(blank_r & (idx != '0) & zero_tail[idx]);
        an   = '1;
        code = BLANK;
        if (lit) begin
            an   = ~(NDIGITS'(1) << idx);
            code = disp[idx];
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: cycle-count reference model, frame table, corner sequences, random traffic.
module tb_seg_scan_driver;

    localparam int ND = 8;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_codes;
    logic        blank_lz;
    logic        en;
    logic [7:0]  an;
    logic [5:0]  code;
    logic        frame_start;

    always #5 clk = ~clk;

    seg_scan_driver #(.NDIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_codes(in_codes), .blank_lz(blank_lz), .en(en), .an(an), .code(code),
        .frame_start(frame_start)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position in the scan derived from cycles elapsed since reset
    int          cyc;
    logic [47:0] disp_m;
    logic [47:0] pend_m;
    bit          pf_m, en_m, blz_m, fs_m;

    typedef struct {
        logic [47:0] frame;
        logic        blz;
        logic [7:0]  dark;
    } vec_t;
    vec_t vt[6];

    task automatic cmp(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc    = 0;
        disp_m = {8{6'h3F}};
        pend_m = '0;
        pf_m   = 0;
        en_m   = 0;
        blz_m  = 0;
        fs_m   = 0;
    endtask

    task automatic model_edge();
        bit tick, bound;
        tick  = (cyc % RD) == RD - 1;
        bound = tick && ((cyc / RD) % ND) == ND - 1;
        fs_m  = bound;
        if (bound && pf_m) begin
            disp_m = pend_m;
            pf_m   = 0;
        end else if (in_valid && !pf_m) begin
            pend_m = in_codes;
            pf_m   = 1;
        end
        en_m  = en;
        blz_m = blank_lz;
        cyc++;
    endtask

    task automatic check_model();
        int         i;
        bit         lz, lit;
        logic [7:0] ea;
        logic [5:0] ec;
        i   = (cyc / RD) % ND;
        lz  = blz_m && (i != 0) && ((disp_m >> (6 * i)) == 48'd0);
        lit = en_m && !lz;
        ea  = 8'hFF;
        ec  = 6'h3F;
        if (lit) begin
            ea = ~(8'd1 << i);
            ec = disp_m[6*i +: 6];
        end
        cmp("model_an", an, ea);
        cmp("model_code", code, ec);
        cmp("model_frame_start", frame_start, fs_m);
        cmp("model_in_ready", in_ready, !pf_m);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_ready(input string name, input int limit);
        int w;
        w = 0;
        while (!in_ready && w < limit) begin
            step();
            w++;
        end
        cmp(name, in_ready, 1'b1);
    endtask

    initial begin
        logic [7:0] ea;
        logic [5:0] ec;

        vt[0] = '{{6'h00,6'h00,6'h00,6'h12,6'h00,6'h0A,6'h00,6'h05}, 1'b1, 8'hE0};
        vt[1] = '{48'd0, 1'b1, 8'hFE};
        vt[2] = '{48'd0, 1'b0, 8'h00};
        vt[3] = '{{6'h09,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00}, 1'b1, 8'h00};
        vt[4] = '{{6'h00,6'h00,6'h00,6'h3E,6'h13,6'h00,6'h00,6'h01}, 1'b1, 8'hE0};
        vt[5] = '{{6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h0F,6'h00}, 1'b1, 8'hFC};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_codes = '0;
        blank_lz = 1'b0;
        en       = 1'b1;
        model_reset();
        repeat (3) step();
        cmp("reset_an", an, 8'hFF);
        cmp("reset_code", code, 6'h3F);
        cmp("reset_ready", in_ready, 1'b1);
        cmp("reset_fs", frame_start, 1'b0);
        reset_n = 1'b1;

        // Free-running scan with no frame loaded
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 1)  cmp("scan_an_k1", an, 8'hFE);
            if (k == 4)  cmp("scan_an_k4", an, 8'hFD);
            if (k == 28) cmp("scan_an_k28", an, 8'h7F);
            if (k == 31) cmp("scan_fs_k31", frame_start, 1'b0);
            if (k == 32) cmp("scan_fs_k32", frame_start, 1'b1);
            if (k == 33) cmp("scan_fs_k33", frame_start, 1'b0);
            if (k == 64) cmp("scan_fs_k64", frame_start, 1'b1);
        end

        // Mid-frame load of digits 0..7 = 01..08
        in_valid = 1'b1;
        in_codes = {6'h08,6'h07,6'h06,6'h05,6'h04,6'h03,6'h02,6'h01};
        step();
        in_valid = 1'b0;
        cmp("load_ready_low", in_ready, 1'b0);
        cmp("load_still_blank", code, 6'h3F);
        wait_ready("load_commit_wait", 40);
        cmp("load_commit_fs", frame_start, 1'b1);
        cmp("load_commit_code", code, 6'h01);
        cmp("load_commit_an", an, 8'hFE);

        // Second frame held while the first is pending
        in_valid = 1'b1;
        in_codes = {6'h11,6'h11,6'h11,6'h11,6'h11,6'h11,6'h11,6'h11};
        step();
        cmp("hold_a_taken", in_ready, 1'b0);
        in_codes = {6'h10,6'h0E,6'h0D,6'h0C,6'h0B,6'h0A,6'h12,6'h0F};
        wait_ready("hold_commit_wait", 40);
        cmp("hold_commit_fs", frame_start, 1'b1);
        cmp("hold_commit_code", code, 6'h11);
        step();
        in_valid = 1'b0;
        cmp("hold_b_taken", in_ready, 1'b0);
        repeat (70) step();

        // Frame table with leading-zero blanking
        for (int v = 0; v < 6; v++) begin
            blank_lz = vt[v].blz;
            wait_ready("tbl_wait_empty", 40);
            in_valid = 1'b1;
            in_codes = vt[v].frame;
            step();
            in_valid = 1'b0;
            wait_ready("tbl_wait_commit", 80);
            cmp("tbl_commit_fs", frame_start, 1'b1);
            for (int d = 0; d < 8; d++) begin
                ea = 8'hFF;
                ec = 6'h3F;
                if (!vt[v].dark[d]) begin
                    ea = ~(8'd1 << d);
                    ec = vt[v].frame[6*d +: 6];
                end
                cmp("tbl_an", an, ea);
                cmp("tbl_code", code, ec);
                repeat (4) step();
            end
        end

        // Display disable while scanning continues
        blank_lz = 1'b0;
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            cmp("en_off_an", an, 8'hFF);
        end
        en = 1'b1;
        repeat (40) step();

        // Random producer traffic and control toggling
        for (int k = 0; k < 500; k++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            for (int d = 0; d < 8; d++) begin
                in_codes[6*d +: 6] = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
            end
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            en = ($urandom_range(0, 7) != 0);
            step();
        end
        in_valid = 1'b0;
        en       = 1'b1;
        blank_lz = 1'b0;

        // Asynchronous reset with a frame pending
        wait_ready("rst_wait_empty", 40);
        while (((cyc / RD) % ND) != 2 && n_cmp < 100000) step();
        in_valid = 1'b1;
        in_codes = {6'h01,6'h02,6'h03,6'h04,6'h05,6'h06,6'h07,6'h08};
        step();
        in_valid = 1'b0;
        step();
        cmp("rst_pend_full", in_ready, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        cmp("rst_async_an", an, 8'hFF);
        cmp("rst_async_code", code, 6'h3F);
        cmp("rst_async_ready", in_ready, 1'b1);
        step();
        reset_n = 1'b1;
        step();
        cmp("rst_after_ready", in_ready, 1'b1);
        cmp("rst_after_an", an, 8'hFE);
        cmp("rst_after_code", code, 6'h3F);
        repeat (80) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
